game_ctrl: RTL and testbench

GAME_CTRL -- requirements
Module: game_ctrl

---
 rtl/game_ctrl.sv | 168 ++++++++++++++++
 tb/tb_game_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_ctrl.sv
// Game controller: button sync, movement tick, floor-contact scoring, lives, IDLE/PLAY/PAUSE/MISS/OVER FSM.
// All outputs registered, transitions land one clk after the qualifying pulse/event; no backpressure.
module game_ctrl #(
  parameter int TICK_DIV   = 1048576,
  parameter int FLOOR_Y    = 475,
  parameter int GAP_LO     = 40,
  parameter int GAP_HI     = 60,
  parameter int MISS_TICKS = 50,
  parameter int LIVES_INIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [9:0] ball_ver,
  input  logic [6:0] ball_hor,
  output logic       ball_rst,
  output logic       ball_en,
  output logic [9:0] score,
  output logic [1:0] lives,
  output logic [2:0] state
);

  localparam int CW = $clog2(TICK_DIV);
  localparam int MW = $clog2(MISS_TICKS + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(TICK_DIV - 1);
  localparam logic [MW-1:0] MISS_MAX  = MW'(MISS_TICKS - 1);
  localparam logic [9:0]    FLOOR_V   = 10'(FLOOR_Y);
  localparam logic [6:0]    GAP_LO_V  = 7'(GAP_LO);
  localparam logic [6:0]    GAP_HI_V  = 7'(GAP_HI);
  localparam logic [1:0]    LIVES_V   = 2'(LIVES_INIT);
  localparam logic [9:0]    SCORE_MAX = 10'd999;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [MW-1:0] mcnt_q, mcnt_d;
  logic [9:0]    score_q, score_d;
  logic [1:0]    lives_q, lives_d;
  logic          ball_rst_q, ball_rst_d;
  logic          ball_en_q, ball_en_d;
  logic [2:0]    start_sync_q, start_sync_d;
  logic [2:0]    pause_sync_q, pause_sync_d;
  logic [1:0]    cmp_q, cmp_d;
  logic [6:0]    hor_q, hor_d;

  logic start_p, pause_p, wrap, contact, in_gap;

  // Bits [1:0] are the synchronizer; bit [2] is the previous level for edge detect.
  assign start_p = start_sync_q[1] & ~start_sync_q[2];
  assign pause_p = pause_sync_q[1] & ~pause_sync_q[2];
  assign wrap    = (cnt_q == CNT_MAX);
  assign contact = (state_q == PLAY) && cmp_q[0] && !cmp_q[1];
  assign in_gap  = (hor_q >= GAP_LO_V) && (hor_q <= GAP_HI_V);

  always_comb begin
    start_sync_d = {start_sync_q[1:0], btn_start};
    pause_sync_d = {pause_sync_q[1:0], btn_pause};
    cmp_d        = {cmp_q[0], (ball_ver >= FLOOR_V)};
    hor_d        = ball_hor;
    state_d      = state_q;
    cnt_d        = cnt_q;
    mcnt_d       = mcnt_q;
    score_d      = score_q;
    lives_d      = lives_q;

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        mcnt_d = '0;
        if (start_p) begin
          score_d = '0;
          lives_d = LIVES_V;
          state_d = PLAY;
        end
      end
      PLAY: begin
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        if (contact && in_gap) begin
          // Restart the tick phase so the hold lasts exactly MISS_TICKS full periods.
          lives_d = lives_q - 2'd1;
          cnt_d   = '0;
          mcnt_d  = '0;
          state_d = MISS;
        end else begin
          if (contact && (score_q != SCORE_MAX)) begin
            score_d = score_q + 10'd1;
          end
          if (pause_p) begin
            state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (pause_p) begin
          state_d = PLAY;
        end
      end
      MISS: begin
        cnt_d = wrap ? '0 : cnt_q + CW'(1);
        if (wrap) begin
          if (mcnt_q == MISS_MAX) begin
            mcnt_d  = '0;
            state_d = (lives_q == 2'd0) ? OVER : PLAY;
          end else begin
            mcnt_d = mcnt_q + MW'(1);
          end
        end
      end
      OVER: begin
        cnt_d  = '0;
        mcnt_d = '0;
        if (start_p) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A wrap coinciding with a miss must not move a ball that is being held.
    ball_en_d  = (state_q == PLAY) && wrap && (state_d != MISS);
    ball_rst_d = (state_d == IDLE) || (state_d == MISS) || (state_d == OVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mcnt_q       <= '0;
      score_q      <= '0;
      lives_q      <= '0;
      ball_rst_q   <= 1'b1;
      ball_en_q    <= 1'b0;
      start_sync_q <= '0;
      pause_sync_q <= '0;
      cmp_q        <= 2'b11;
      hor_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mcnt_q       <= mcnt_d;
      score_q      <= score_d;
      lives_q      <= lives_d;
      ball_rst_q   <= ball_rst_d;
      ball_en_q    <= ball_en_d;
      start_sync_q <= start_sync_d;
      pause_sync_q <= pause_sync_d;
      cmp_q        <= cmp_d;
      hor_q        <= hor_d;
    end
  end

  assign ball_rst = ball_rst_q;
  assign ball_en  = ball_en_q;
  assign score    = score_q;
  assign lives    = lives_q;
  assign state    = state_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed sequences, a contact table and randomized play against a game-rule model.
module tb_game_ctrl;

  localparam int TICK_DIV   = 4;
  localparam int MISS_TICKS = 2;
  localparam int LIVES_INIT = 3;
  localparam int MISS_LEN   = TICK_DIV * MISS_TICKS;

  logic       clk       = 1'b0;
  logic       rst       = 1'b0;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic [9:0] ball_ver  = 10'd0;
  logic [6:0] ball_hor  = 7'd0;
  logic       ball_rst;
  logic       ball_en;
  logic [9:0] score;
  logic [1:0] lives;
  logic [2:0] state;

  always #5 clk = ~clk;

  game_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .FLOOR_Y   (475),
    .GAP_LO    (40),
    .GAP_HI    (60),
    .MISS_TICKS(MISS_TICKS),
    .LIVES_INIT(LIVES_INIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .ball_ver (ball_ver),
    .ball_hor (ball_hor),
    .ball_rst (ball_rst),
    .ball_en  (ball_en),
    .score    (score),
    .lives    (lives),
    .state    (state)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int hor;
    int exp_score;
    int exp_lives;
    int exp_state;
    int exp_after;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_start();
    btn_start = 1'b1;
    tick(4);
    btn_start = 1'b0;
    tick(4);
  endtask

  task automatic press_pause();
    btn_pause = 1'b1;
    tick(4);
    btn_pause = 1'b0;
    tick(4);
  endtask

  // Leaves the bench sampling just after the edge where the contact took effect.
  task automatic contact(input int h);
    ball_ver = 10'd0;
    tick(2);
    ball_hor = 7'(h);
    ball_ver = 10'd475;
    tick(2);
    ball_ver = 10'd0;
  endtask

  task automatic wait_miss_exit(input string name);
    int cyc;
    cyc = 0;
    while (state == 3'd3 && cyc < 40) begin
      if (ball_rst !== 1'b1 || ball_en !== 1'b0) begin
        chk({name, "_hold_outputs"}, {ball_rst, ball_en}, 2'b10);
      end
      tick(1);
      cyc++;
    end
    chk({name, "_miss_len"}, cyc, MISS_LEN);
  endtask

  int k, cnt, gap, prev, h, act, rst_cyc, en_cyc;
  int m_score, m_lives;

  initial begin
    vecs[0] = '{0,   1, 3, 1, 1};
    vecs[1] = '{39,  2, 3, 1, 1};
    vecs[2] = '{40,  2, 2, 3, 1};
    vecs[3] = '{61,  3, 2, 1, 1};
    vecs[4] = '{60,  3, 1, 3, 1};
    vecs[5] = '{127, 4, 1, 1, 1};
    vecs[6] = '{50,  4, 0, 3, 4};

    tick(3);
    chk("rst_state", state, 0);
    chk("rst_ball_rst", ball_rst, 1);
    chk("rst_ball_en", ball_en, 0);
    chk("rst_score", score, 0);
    chk("rst_lives", lives, 0);
    rst = 1'b1;
    tick(5);
    chk("idle_after_release", state, 0);
    chk("idle_ball_rst", ball_rst, 1);
    press_pause();
    chk("pause_ignored_idle", state, 0);

    press_start();
    chk("start_state", state, 1);
    chk("start_lives", lives, 3);
    chk("start_score", score, 0);
    chk("play_ball_rst", ball_rst, 0);

    cnt = 0; gap = 0; prev = -1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (ball_en) begin
        if (prev >= 0 && gap == 0) gap = i - prev;
        prev = i;
        cnt++;
      end
    end
    chk("tick_count", cnt, 5);
    chk("tick_spacing", gap, TICK_DIV);

    ball_hor = 7'd20;
    for (int v = 471; v <= 475; v++) begin
      ball_ver = 10'(v);
      tick(1);
    end
    tick(1);
    chk("hit_once", score, 1);
    tick(10);
    chk("hit_hold_no_repeat", score, 1);
    ball_ver = 10'd0;

    press_start();
    chk("start_ignored_play", state, 1);
    chk("start_ignored_score", score, 1);

    contact(50);
    chk("miss_state", state, 3);
    chk("miss_lives", lives, 2);
    rst_cyc = 0; en_cyc = 0; k = 0;
    while (state == 3'd3 && k < 40) begin
      if (k == 1) begin btn_pause = 1'b1; btn_start = 1'b1; end
      if (k == 5) begin btn_pause = 1'b0; btn_start = 1'b0; end
      if (ball_rst) rst_cyc++;
      if (ball_en) en_cyc++;
      tick(1);
      k++;
    end
    chk("miss_ball_rst_cycles", rst_cyc, MISS_LEN);
    chk("miss_ball_en_cycles", en_cyc, 0);
    chk("miss_exit_state", state, 1);
    chk("miss_exit_ball_rst", ball_rst, 0);
    chk("miss_buttons_ignored_lives", lives, 2);

    for (int m = 0; m < 2; m++) begin
      contact(45);
      chk("over_run_miss_state", state, 3);
      wait_miss_exit("over_run");
    end
    chk("over_state", state, 4);
    chk("over_lives", lives, 0);
    chk("over_ball_rst", ball_rst, 1);
    press_pause();
    chk("pause_ignored_over", state, 4);
    press_start();
    chk("over_to_idle", state, 0);
    chk("idle_score_held", score, 1);
    press_start();
    chk("restart_state", state, 1);
    chk("restart_lives", lives, 3);
    chk("restart_score", score, 0);

    for (int i = 0; i < 7; i++) begin
      contact(vecs[i].hor);
      chk($sformatf("vec%0d_score", i), score, vecs[i].exp_score);
      chk($sformatf("vec%0d_lives", i), lives, vecs[i].exp_lives);
      chk($sformatf("vec%0d_state", i), state, vecs[i].exp_state);
      if (state == 3'd3) wait_miss_exit($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_after", i), state, vecs[i].exp_after);
    end

    press_start();
    press_start();
    chk("fresh_state", state, 1);

    // Pause two clk after a tick: counter freezes at 1, so resume needs 3 more clk.
    k = 0;
    while (!ball_en && k < 10) begin tick(1); k++; end
    chk("align_tick_found", ball_en, 1);
    tick(2);
    press_pause();
    chk("pause_state", state, 2);
    en_cyc = 0;
    for (int i = 0; i < 12; i++) begin
      if (ball_en) en_cyc++;
      tick(1);
    end
    chk("pause_no_ball_en", en_cyc, 0);
    chk("pause_held", state, 2);
    btn_pause = 1'b1;
    k = 0;
    while (state != 3'd1 && k < 10) begin tick(1); k++; end
    chk("resume_state", state, 1);
    k = 0;
    while (k < 10) begin
      tick(1);
      k++;
      if (ball_en) break;
    end
    chk("resume_remaining_count", k, 3);
    btn_pause = 1'b0;
    tick(4);

    btn_pause = 1'b1;
    tick(1);
    ball_hor = 7'd50;
    ball_ver = 10'd475;
    tick(2);
    chk("pause_vs_miss_state", state, 3);
    chk("pause_vs_miss_lives", lives, 2);
    ball_ver = 10'd0;
    btn_pause = 1'b0;
    wait_miss_exit("pause_vs_miss");
    chk("pause_vs_miss_after", state, 1);

    m_score = 0;
    m_lives = 2;
    for (int it = 0; it < 150; it++) begin
      tick($urandom_range(0, 5));
      act = $urandom_range(0, 9);
      if (act < 6) begin
        h = $urandom_range(0, 127 - 21);
        if (h >= 40) h = h + 21;
        contact(h);
        m_score = (m_score < 999) ? m_score + 1 : 999;
        chk("rnd_hit_score", score, m_score);
        chk("rnd_hit_state", state, 1);
      end else if (act < 8) begin
        contact($urandom_range(40, 60));
        m_lives = m_lives - 1;
        chk("rnd_miss_lives", lives, m_lives);
        chk("rnd_miss_score", score, m_score);
        chk("rnd_miss_state", state, 3);
        wait_miss_exit("rnd");
        chk("rnd_miss_after", state, (m_lives == 0) ? 4 : 1);
        if (m_lives == 0) begin
          press_start();
          chk("rnd_over_idle", state, 0);
          press_start();
          m_score = 0;
          m_lives = LIVES_INIT;
          chk("rnd_restart_state", state, 1);
          chk("rnd_restart_lives", lives, m_lives);
          chk("rnd_restart_score", score, m_score);
        end
      end else begin
        press_pause();
        chk("rnd_pause_state", state, 2);
        tick($urandom_range(0, 6));
        press_pause();
        chk("rnd_resume_state", state, 1);
        chk("rnd_pause_score", score, m_score);
      end
    end

    while (m_score < 999) begin
      contact(20);
      m_score++;
    end
    chk("sat_score_999", score, 999);
    contact(100);
    chk("sat_score_hold", score, 999);

    contact(55);
    tick(3);
    chk("rst_mid_miss_pre", state, 3);
    rst = 1'b0;
    #1;
    chk("rst_mid_miss_state", state, 0);
    chk("rst_mid_miss_ball_rst", ball_rst, 1);
    chk("rst_mid_miss_ball_en", ball_en, 0);
    chk("rst_mid_miss_score", score, 0);
    chk("rst_mid_miss_lives", lives, 0);
    tick(2);
    rst = 1'b1;
    tick(5);
    chk("rst_mid_miss_idle", state, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
